// File: rtl/lsu_bank_arbiter_pkg.sv
// Shared definitions for the LSU bank arbiter: bank-select width, default
// address width, perf-counter width, the per-LSU read/write phase encoding
// and a saturating-increment helper for the optional conflict counters.
package lsu_bank_arbiter_pkg;

  localparam int BSEL_W     = 2;
  localparam int DEF_ADDR_W = 10;
  localparam int PERF_W     = 32;

  // Per-LSU phase: PH_READ serves the read (if any) first, PH_WRITE means the
  // read of a read+write pair is done and only the write is still pending.
  typedef enum logic {
    PH_READ  = 1'b0,
    PH_WRITE = 1'b1
  } phase_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lsu_bank_arbiter_rr.sv
// NUM_LSU-way round-robin arbiter with its own pointer register.
// The grant goes to the first requester at or after ptr_q; after a grant the
// pointer moves just past the winner, otherwise it holds.
module lsu_rr_arbiter #(
  parameter int NUM_LSU = 4,
  localparam int ID_W = $clog2(NUM_LSU)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_LSU-1:0] req,
  output logic [NUM_LSU-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Scan requesters starting at the pointer, wrapping once around.
  always_comb begin
    int  cand;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    ptr_d  = ptr_q;
    cand   = 0;
    found  = 1'b0;
    for (int k = 0; k < NUM_LSU; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_LSU) cand = cand - NUM_LSU;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_id    = ID_W'(cand);
        ptr_d     = (cand == NUM_LSU - 1) ? '0 : ID_W'(cand + 1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lsu_bank_arbiter.sv
// LSU-to-bank arbiter: per-bank round-robin arbitration of the LSUs' read and
// write requests, registered SRAM command ports, and read-data return routing
// back to the requesting LSU (2-cycle read latency).
// Optional feature macro: LSU_ARB_PERF_EN (per-bank 32-bit saturating
// conflict counters on perf_conflict; tied to 0 when undefined).
//
// Handshake: an LSU presents a request and holds every request input while
// stall is high; the cycle stall is low (or no valid request) it may change.
module lsu_bank_arbiter
  import lsu_bank_arbiter_pkg::*;
#(
  parameter int NUM_LSU  = 4,
  parameter int NUM_BANK = 4,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LSU-1:0]         req_ren,
  input  logic [2*NUM_LSU-1:0]       req_rsel,
  input  logic [NUM_LSU-1:0]         req_wen,
  input  logic [2*NUM_LSU-1:0]       req_wsel,
  input  logic [ADDR_W*NUM_LSU-1:0]  req_addr,
  input  logic [DATA_W*NUM_LSU-1:0]  req_wdata,
  output logic [NUM_LSU-1:0]         stall,
  output logic [NUM_BANK-1:0]        bank_en,
  output logic [NUM_BANK-1:0]        bank_we,
  output logic [ADDR_W*NUM_BANK-1:0] bank_addr,
  output logic [DATA_W*NUM_BANK-1:0] bank_wdata,
  input  logic [DATA_W*NUM_BANK-1:0] bank_rdata,
  output logic [NUM_LSU-1:0]         rd_valid,
  output logic [DATA_W*NUM_LSU-1:0]  rd_data,
  output logic [PERF_W*NUM_BANK-1:0] perf_conflict
);

  localparam int ID_W = $clog2(NUM_LSU);

  phase_e                phase_q [NUM_LSU];
  phase_e                phase_d [NUM_LSU];
  logic [NUM_LSU-1:0]    eff_rd;
  logic [NUM_LSU-1:0]    eff_vld;
  logic [NUM_LSU-1:0]    wr_ok;
  logic [NUM_LSU-1:0]    granted;
  logic [BSEL_W-1:0]     eff_sel [NUM_LSU];
  logic [NUM_LSU-1:0]    bank_req [NUM_BANK];
  logic [NUM_LSU-1:0]    bank_gnt [NUM_BANK];
  logic [ID_W-1:0]       bank_gid [NUM_BANK];

  logic [NUM_BANK-1:0]        bank_en_q, bank_en_d;
  logic [NUM_BANK-1:0]        bank_we_q, bank_we_d;
  logic [ADDR_W*NUM_BANK-1:0] bank_addr_q, bank_addr_d;
  logic [DATA_W*NUM_BANK-1:0] bank_wdata_q, bank_wdata_d;
  logic [ID_W-1:0]            cmd_id_q [NUM_BANK];
  logic [ID_W-1:0]            cmd_id_d [NUM_BANK];
  logic [NUM_BANK-1:0]        ret_vld_q, ret_vld_d;
  logic [ID_W-1:0]            ret_id_q [NUM_BANK];
  logic [ID_W-1:0]            ret_id_d [NUM_BANK];

  // Effective request per LSU (read first) and per-bank request vectors;
  // out-of-range bank selects are dropped here.
  always_comb begin
    eff_rd  = '0;
    eff_vld = '0;
    wr_ok   = '0;
    for (int i = 0; i < NUM_LSU; i++) begin
      eff_sel[i] = '0;
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_req[b] = '0;
    end
    for (int i = 0; i < NUM_LSU; i++) begin
      eff_rd[i]  = req_ren[i] && (phase_q[i] == PH_READ);
      eff_sel[i] = eff_rd[i] ? req_rsel[BSEL_W*i +: BSEL_W]
                             : req_wsel[BSEL_W*i +: BSEL_W];
      eff_vld[i] = (eff_rd[i] || req_wen[i]) && (32'(eff_sel[i]) < NUM_BANK);
      wr_ok[i]   = req_wen[i] && (32'(req_wsel[BSEL_W*i +: BSEL_W]) < NUM_BANK);
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int i = 0; i < NUM_LSU; i++) begin
        bank_req[b][i] = eff_vld[i] && (32'(eff_sel[i]) == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    lsu_rr_arbiter #(.NUM_LSU(NUM_LSU)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bank_req[b]),
      .gnt    (bank_gnt[b]),
      .gnt_id (bank_gid[b])
    );
  end

  // Stall and read/write phase next-state per LSU.
  always_comb begin
    granted = '0;
    stall   = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      granted = granted | bank_gnt[b];
    end
    for (int i = 0; i < NUM_LSU; i++) begin
      phase_d[i] = PH_READ;
      if (eff_vld[i]) begin
        if (!granted[i]) begin
          stall[i]   = 1'b1;
          phase_d[i] = phase_q[i];
        end else if (eff_rd[i] && wr_ok[i]) begin
          stall[i]   = 1'b1;
          phase_d[i] = PH_WRITE;
        end
      end
    end
  end

  // Bank command mux (zero when idle) and read-tag pipeline next state.
  always_comb begin
    bank_en_d    = '0;
    bank_we_d    = '0;
    bank_addr_d  = '0;
    bank_wdata_d = '0;
    ret_vld_d    = bank_en_q & ~bank_we_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      cmd_id_d[b] = bank_gid[b];
      ret_id_d[b] = cmd_id_q[b];
      bank_en_d[b] = |bank_gnt[b];
      for (int i = 0; i < NUM_LSU; i++) begin
        if (bank_gnt[b][i]) begin
          bank_we_d[b] = !eff_rd[i];
          bank_addr_d[ADDR_W*b +: ADDR_W]  = req_addr[ADDR_W*i +: ADDR_W];
          bank_wdata_d[DATA_W*b +: DATA_W] = req_wdata[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  // State registers: phases, bank command, and two-stage read tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_en_q    <= '0;
      bank_we_q    <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      ret_vld_q    <= '0;
      for (int i = 0; i < NUM_LSU; i++) phase_q[i] <= PH_READ;
      for (int b = 0; b < NUM_BANK; b++) begin
        cmd_id_q[b] <= '0;
        ret_id_q[b] <= '0;
      end
    end else begin
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      ret_vld_q    <= ret_vld_d;
      for (int i = 0; i < NUM_LSU; i++) phase_q[i] <= phase_d[i];
      for (int b = 0; b < NUM_BANK; b++) begin
        cmd_id_q[b] <= cmd_id_d[b];
        ret_id_q[b] <= ret_id_d[b];
      end
    end
  end

  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

  // Steer each returning bank's data to the LSU named by its tag.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int i = 0; i < NUM_LSU; i++) begin
        if (ret_vld_q[b] && (ret_id_q[b] == ID_W'(i))) begin
          rd_valid[i] = 1'b1;
          rd_data[DATA_W*i +: DATA_W] = bank_rdata[DATA_W*b +: DATA_W];
        end
      end
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [PERF_W-1:0] perf_q [NUM_BANK];
  logic [PERF_W-1:0] perf_d [NUM_BANK];

  // Count cycles in which some requester of the bank lost arbitration.
  always_comb begin
    perf_conflict = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      perf_d[b] = ((bank_req[b] & ~bank_gnt[b]) != '0) ? sat_inc(perf_q[b]) : perf_q[b];
      perf_conflict[PERF_W*b +: PERF_W] = perf_q[b];
    end
  end

  // Conflict counter registers.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (!rst_n) perf_q[b] <= '0;
      else        perf_q[b] <= perf_d[b];
    end
  end
`else
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_lsu_bank_arbiter.sv
// Self-checking bench for lsu_bank_arbiter: behavioural SRAM banks, directed
// scenarios (single read, 4-way conflict, read+write phasing, parallel banks,
// reset mid-read, perf counter) plus random back-to-back reads.
module tb_lsu_bank_arbiter;
  localparam int NL = 4;
  localparam int NB = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL-1:0]   req_ren, req_wen;
  logic [2*NL-1:0] req_rsel, req_wsel;
  logic [AW*NL-1:0] req_addr;
  logic [DW*NL-1:0] req_wdata;
  logic [NL-1:0]   stall;
  logic [NB-1:0]   bank_en, bank_we;
  logic [AW*NB-1:0] bank_addr;
  logic [DW*NB-1:0] bank_wdata, bank_rdata;
  logic [NL-1:0]   rd_valid;
  logic [DW*NL-1:0] rd_data;
  logic [32*NB-1:0] perf_conflict;

  lsu_bank_arbiter #(.NUM_LSU(NL), .NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ren(req_ren), .req_rsel(req_rsel), .req_wen(req_wen), .req_wsel(req_wsel),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .perf_conflict(perf_conflict)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM banks.
  logic [DW-1:0] mem [NB][1024];
  logic [DW-1:0] sram_q [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem[b][bank_addr[AW*b +: AW]] <= bank_wdata[DW*b +: DW];
        else            sram_q[b] <= mem[b][bank_addr[AW*b +: AW]];
      end
    end
  end
  always_comb begin
    for (int b = 0; b < NB; b++) bank_rdata[DW*b +: DW] = sram_q[b];
  end

  // Checking.
  int n_checks = 0;
  int n_errors = 0;
  int n_ret = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every read return is compared against the queue head.
  always @(negedge clk) begin
    logic [35:0] e;
    for (int i = 0; i < NL; i++) begin
      if (rd_valid[i]) begin
        n_ret++;
        if (exp_q.size() == 0) begin
          check("rd_unexp", 64'(rd_valid[i]), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_ret", 64'({4'(i), rd_data[DW*i +: DW]}), 64'(e));
        end
      end
    end
  end

  // Driver helpers.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_ren = '0; req_wen = '0; req_rsel = '0; req_wsel = '0;
    req_addr = '0; req_wdata = '0;
  endtask

  task automatic drv_read(input int i, input int b, input int a);
    req_ren[i] = 1'b1;
    req_rsel[2*i +: 2] = 2'(b);
    req_addr[AW*i +: AW] = AW'(a);
  endtask

  function automatic logic [AW-1:0] baddr(input int b);
    return bank_addr[AW*b +: AW];
  endfunction

  function automatic logic [DW-1:0] bwdata(input int b);
    return bank_wdata[DW*b +: DW];
  endfunction

  logic [NL-1:0] mask;
  int exp_rets;
  logic [31:0] exp_perf;

  initial begin
    int li, lb, la;
    idle();
    exp_rets = 0;
    for (int b = 0; b < NB; b++) begin
      sram_q[b] = '0;
      for (int a = 0; a < 1024; a++) mem[b][a] = $urandom;
    end
    mem[1][5] = 32'hA5A5_0001;

    // Reset state.
    repeat (2) step();
    check("rst_bank_en", 64'(bank_en), 64'd0);
    check("rst_bank_we", 64'(bank_we), 64'd0);
    check("rst_bank_addr", 64'(bank_addr), 64'd0);
    check("rst_bank_wdata", 64'(bank_wdata[63:0]), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data[63:0]), 64'd0);
    // Stall is combinational even in reset: LSU0 wins bank 0, LSU1 stalls.
    req_wen = 4'b0011;
    #2;
    check("rst_stall", 64'(stall), 64'h2);
    idle();
    step();
    rst_n = 1'b1;
    step();

    // Single read: LSU0, bank 1, addr 5.
    drv_read(0, 1, 5);
    #2;
    check("t1_stall_T", 64'(stall), 64'd0);
    exp_q.push_back({4'd0, 32'hA5A5_0001}); exp_rets++;
    step();
    idle();
    check("t1_bank_en", 64'(bank_en), 64'h2);
    check("t1_bank_we", 64'(bank_we), 64'd0);
    check("t1_bank_addr", 64'(baddr(1)), 64'd5);
    #2;
    check("t1_stall_T1", 64'(stall), 64'd0);
    repeat (2) step();

    // Four-way write conflict on bank 0.
    mask = 4'hF;
    for (int c = 0; c < 4; c++) begin
      req_wen = mask;
      req_wsel = '0;
      for (int i = 0; i < NL; i++) begin
        req_addr[AW*i +: AW] = AW'(16 + i);
        req_wdata[DW*i +: DW] = 32'hC0DE_0000 + i;
      end
      #2;
      check("t2_stall", 64'(stall), 64'(mask & ~(4'b0001 << c)));
      step();
      mask = mask & ~(4'b0001 << c);
      req_wen = mask;
      check("t2_bank_en", 64'(bank_en), 64'h1);
      check("t2_bank_we", 64'(bank_we), 64'h1);
      check("t2_bank_addr", 64'(baddr(0)), 64'(16 + c));
      check("t2_bank_wdata", 64'(bwdata(0)), 64'(32'hC0DE_0000 + c));
    end
    idle();
    check("t2_ptr0", 64'(dut.g_bank[0].u_arb.ptr_q), 64'd0);
`ifdef LSU_ARB_PERF_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    check("t2_perf0", 64'(perf_conflict[31:0]), 64'(exp_perf));
    step();

    // Read+write phasing: LSU2 reads bank 3 then writes bank 0, addr 7.
    drv_read(2, 3, 7);
    req_wen[2] = 1'b1;
    req_wsel[5:4] = 2'd0;
    req_wdata[DW*2 +: DW] = 32'h7777_2222;
    #2;
    check("t3_stall_T", 64'(stall), 64'h4);
    exp_q.push_back({4'd2, mem[3][7]}); exp_rets++;
    step();
    check("t3_rd_en", 64'(bank_en), 64'h8);
    check("t3_rd_we", 64'(bank_we), 64'd0);
    check("t3_rd_addr", 64'(baddr(3)), 64'd7);
    #2;
    check("t3_stall_T1", 64'(stall), 64'd0);
    step();
    idle();
    check("t3_wr_en", 64'(bank_en), 64'h1);
    check("t3_wr_we", 64'(bank_we), 64'h1);
    check("t3_wr_addr", 64'(baddr(0)), 64'd7);
    check("t3_wr_data", 64'(bwdata(0)), 64'h7777_2222);
    repeat (2) step();

    // Parallel banks: LSU i reads bank i.
    drv_read(0, 0, 16);
    drv_read(1, 1, 5);
    drv_read(2, 2, 33);
    drv_read(3, 3, 9);
    #2;
    check("t4_stall", 64'(stall), 64'd0);
    exp_q.push_back({4'd0, 32'hC0DE_0000});
    exp_q.push_back({4'd1, 32'hA5A5_0001});
    exp_q.push_back({4'd2, mem[2][33]});
    exp_q.push_back({4'd3, mem[3][9]});
    exp_rets += 4;
    step();
    idle();
    check("t4_bank_en", 64'(bank_en), 64'hF);
    check("t4_bank_we", 64'(bank_we), 64'd0);
    repeat (3) step();

    // Reset mid-read: LSU1 reads bank 2, reset in the following cycle.
    drv_read(1, 2, 3);
    step();
    idle();
    check("t5_bank_en_T1", 64'(bank_en), 64'h4);
    rst_n = 1'b0;
    step();
    check("t5_rd_valid", 64'(rd_valid), 64'd0);
    check("t5_bank_en", 64'(bank_en), 64'd0);
    check("t5_bank_addr", 64'(bank_addr), 64'd0);
    check("t5_ptr2", 64'(dut.g_bank[2].u_arb.ptr_q), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Random back-to-back single reads.
    for (int n = 0; n < 24; n++) begin
      idle();
      li = $urandom_range(0, NL - 1);
      lb = $urandom_range(0, NB - 1);
      la = $urandom_range(100, 1023);
      drv_read(li, lb, la);
      exp_q.push_back({4'(li), mem[lb][la]}); exp_rets++;
      #2;
      check("rnd_stall", 64'(stall), 64'd0);
      step();
      check("rnd_bank_en", 64'(bank_en), 64'(4'b0001 << lb));
    end
    idle();
    repeat (4) step();

    check("ret_count", 64'(n_ret), 64'(exp_rets));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
